// File: rtl/pen_lift_ctrl_if.sv
// Command handshake bundle between a host sequencer and pen_lift_ctrl.
// The host owns cmd_valid/cmd_pen; the controller answers with cmd_ready and a one-cycle done.
interface pen_lift_ctrl_if;
  logic cmd_valid;
  logic cmd_pen;
  logic cmd_ready;
  logic done;

  modport master (output cmd_valid, output cmd_pen, input cmd_ready, input done);
  modport slave  (input cmd_valid, input cmd_pen, output cmd_ready, output done);
endinterface

// File: rtl/pen_lift_ctrl.sv
// Pen lift servo controller: debounced limit switch, drive/settle sequencing and fault handling.
// Define PEN_TIMEOUT_EN to enable the DRIVE timeout counter and timeout_err.
module pen_lift_ctrl #(
  parameter int          DEBOUNCE_CYCLES = 50000,
  parameter int          SETTLE_CYCLES   = 500000,
  parameter int          TIMEOUT_CYCLES  = 25000000,
  parameter logic [15:0] DUTY_MOVE       = 16'd128
) (
  input  logic          clk_50,
  input  logic          reset_n,
  pen_lift_ctrl_if.slave cmd,
  input  logic          limit_switch,
  input  logic          fault_n,
  input  logic          clear_err,
  output logic          motor_enable,
  output logic          set_pen,
  output logic [15:0]   duty,
  output logic          error,
  output logic          timeout_err,
  output logic          pen_db,
  output logic          busy
);

  localparam int DebW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int SetW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [DebW-1:0] DebLast = DebW'(DEBOUNCE_CYCLES - 1);
  localparam logic [SetW-1:0] SetLast = SetW'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, DONE, FAULT} state_t;

  state_t            state_q;
  logic              limSync1_q, limSync2_q;
  logic              fltSync1_q, fltSync2_q;
  logic [DebW-1:0]   debCnt_q, debCnt_d;
  logic              penDb_q, penDb_d;
  logic [SetW-1:0]   settleCnt_q;
  logic              motorEn_q, setPen_q, done_q, error_q, busy_q, ready_q;
  logic [15:0]       duty_q;

`ifdef PEN_TIMEOUT_EN
  localparam int ToW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [ToW-1:0] ToLast = ToW'(TIMEOUT_CYCLES - 1);
  logic [ToW-1:0]    driveCnt_q;
  logic              timeoutErr_q;
  assign timeout_err = timeoutErr_q;
`else
  // Timeout disabled: constant 0 for any legal TIMEOUT_CYCLES.
  assign timeout_err = (TIMEOUT_CYCLES < 0);
`endif

  // Idle level of both synchronizers is "pen up, no fault".
  always_ff @(posedge clk_50) begin
    if (!reset_n) begin
      limSync1_q <= 1'b1;
      limSync2_q <= 1'b1;
      fltSync1_q <= 1'b1;
      fltSync2_q <= 1'b1;
    end else begin
      limSync1_q <= limit_switch;
      limSync2_q <= limSync1_q;
      fltSync1_q <= fault_n;
      fltSync2_q <= fltSync1_q;
    end
  end

  always_comb begin
    debCnt_d = '0;
    penDb_d  = penDb_q;
    if (!limSync2_q != penDb_q) begin
      if (debCnt_q == DebLast) penDb_d = !limSync2_q;
      else                     debCnt_d = debCnt_q + DebW'(1);
    end
  end

  always_ff @(posedge clk_50) begin
    if (!reset_n) begin
      debCnt_q <= '0;
      penDb_q  <= 1'b0;
    end else begin
      debCnt_q <= debCnt_d;
      penDb_q  <= penDb_d;
    end
  end

  // Outputs are registered alongside the state; a low fault_n always wins over arrival or timeout.
  always_ff @(posedge clk_50) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      motorEn_q    <= 1'b0;
      duty_q       <= '0;
      setPen_q     <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      busy_q       <= 1'b0;
      ready_q      <= 1'b1;
      settleCnt_q  <= '0;
`ifdef PEN_TIMEOUT_EN
      driveCnt_q   <= '0;
      timeoutErr_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!fltSync2_q) begin
            state_q <= FAULT;
            error_q <= 1'b1;
            ready_q <= 1'b0;
          end else if (cmd.cmd_valid && ready_q) begin
            setPen_q <= cmd.cmd_pen;
            ready_q  <= 1'b0;
            busy_q   <= 1'b1;
            if (penDb_q == cmd.cmd_pen) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q   <= DRIVE;
              motorEn_q <= 1'b1;
              duty_q    <= DUTY_MOVE;
`ifdef PEN_TIMEOUT_EN
              driveCnt_q <= '0;
`endif
            end
          end
        end
        DRIVE: begin
          if (!fltSync2_q) begin
            state_q   <= FAULT;
            error_q   <= 1'b1;
            motorEn_q <= 1'b0;
            duty_q    <= '0;
            busy_q    <= 1'b0;
          end else if (penDb_q == setPen_q) begin
            state_q     <= SETTLE;
            motorEn_q   <= 1'b0;
            duty_q      <= '0;
            settleCnt_q <= '0;
          end
`ifdef PEN_TIMEOUT_EN
          else if (driveCnt_q == ToLast) begin
            state_q      <= FAULT;
            error_q      <= 1'b1;
            timeoutErr_q <= 1'b1;
            motorEn_q    <= 1'b0;
            duty_q       <= '0;
            busy_q       <= 1'b0;
          end else begin
            driveCnt_q <= driveCnt_q + ToW'(1);
          end
`endif
        end
        SETTLE: begin
          if (!fltSync2_q) begin
            state_q <= FAULT;
            error_q <= 1'b1;
            busy_q  <= 1'b0;
          end else if (settleCnt_q == SetLast) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            settleCnt_q <= settleCnt_q + SetW'(1);
          end
        end
        DONE: begin
          if (!fltSync2_q) begin
            state_q <= FAULT;
            error_q <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        FAULT: begin
          if (clear_err && fltSync2_q) begin
            state_q <= IDLE;
            error_q <= 1'b0;
            ready_q <= 1'b1;
`ifdef PEN_TIMEOUT_EN
            timeoutErr_q <= 1'b0;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd.cmd_ready = ready_q;
  assign cmd.done      = done_q;
  assign motor_enable  = motorEn_q;
  assign set_pen       = setPen_q;
  assign duty          = duty_q;
  assign error         = error_q;
  assign pen_db        = penDb_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_pen_lift_ctrl.sv
// Self-checking bench for pen_lift_ctrl: vector table, directed corner cases and a randomized
// run against a behavioural model. Honors PEN_TIMEOUT_EN the same way as the design.
module tb_pen_lift_ctrl;

  localparam int          DEB  = 4;
  localparam int          SET  = 8;
  localparam int          TO   = 100;
  localparam logic [15:0] DUTY = 16'h80;

  logic        clk_50 = 1'b0;
  logic        reset_n, limit_switch, fault_n, clear_err;
  logic        motor_enable, set_pen, error, timeout_err, pen_db, busy;
  logic [15:0] duty;
  int          checks = 0;
  int          failures = 0;

  pen_lift_ctrl_if cmdIf();

  pen_lift_ctrl #(
    .DEBOUNCE_CYCLES(DEB), .SETTLE_CYCLES(SET), .TIMEOUT_CYCLES(TO), .DUTY_MOVE(DUTY)
  ) dut (
    .clk_50(clk_50), .reset_n(reset_n), .cmd(cmdIf.slave),
    .limit_switch(limit_switch), .fault_n(fault_n), .clear_err(clear_err),
    .motor_enable(motor_enable), .set_pen(set_pen), .duty(duty), .error(error),
    .timeout_err(timeout_err), .pen_db(pen_db), .busy(busy)
  );

  always #5 clk_50 = ~clk_50;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got no finish expected finish before 2ms");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkBit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic checkWord(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkVec(input string name, input logic [5:0] act, input logic [5:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %b expected %b (ready,me,done,busy,err,pen_db)", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic rstN, input logic valid, input logic pen,
                               input logic lim, input logic fltN, input logic clr);
    reset_n         = rstN;
    cmdIf.cmd_valid = valid;
    cmdIf.cmd_pen   = pen;
    limit_switch    = lim;
    fault_n         = fltN;
    clear_err       = clr;
  endtask

  task automatic tick();
    @(posedge clk_50);
    #1;
  endtask

  // Behavioural model: delay lines for the synchronizers, run-length debounce, phase + countdowns.
  typedef enum {M_IDLE, M_MOVE, M_WAIT, M_FIN, M_ERR} mode_t;
  mode_t mMode;
  bit    mSetPen, mPenDb, mTimeoutErr;
  int    mRun, mDriveCycles, mSettleLeft;
  bit    limLine[$];
  bit    fltLine[$];

  task automatic modelEdge(input bit rstN, input bit valid, input bit pen,
                           input bit lim, input bit fltN, input bit clr);
    bit sLim, sFlt;
    if (!rstN) begin
      mMode = M_IDLE; mSetPen = 0; mPenDb = 0; mTimeoutErr = 0; mRun = 0;
      mDriveCycles = 0; mSettleLeft = 0;
      limLine = {1'b1, 1'b1};
      fltLine = {1'b1, 1'b1};
      return;
    end
    sLim = limLine[0];
    sFlt = fltLine[0];
    case (mMode)
      M_IDLE:
        if (!sFlt) mMode = M_ERR;
        else if (valid) begin
          mSetPen = pen;
          if (pen == mPenDb) mMode = M_FIN;
          else begin mMode = M_MOVE; mDriveCycles = 0; end
        end
      M_MOVE:
        if (!sFlt) mMode = M_ERR;
        else if (mPenDb == mSetPen) begin mMode = M_WAIT; mSettleLeft = SET; end
        else begin
          mDriveCycles++;
`ifdef PEN_TIMEOUT_EN
          if (mDriveCycles == TO) begin mMode = M_ERR; mTimeoutErr = 1; end
`endif
        end
      M_WAIT:
        if (!sFlt) mMode = M_ERR;
        else begin
          mSettleLeft--;
          if (mSettleLeft == 0) mMode = M_FIN;
        end
      M_FIN:
        mMode = sFlt ? M_IDLE : M_ERR;
      M_ERR:
        if (clr && sFlt) begin mMode = M_IDLE; mTimeoutErr = 0; end
      default: mMode = M_IDLE;
    endcase
    if ((!sLim) != mPenDb) begin
      mRun++;
      if (mRun == DEB) begin mPenDb = !sLim; mRun = 0; end
    end else mRun = 0;
    void'(limLine.pop_front());
    limLine.push_back(lim);
    void'(fltLine.pop_front());
    fltLine.push_back(fltN);
  endtask

  typedef struct {
    logic [5:0] stim;  // rstN, valid, pen, lim, fltN, clr
    logic [5:0] expv;  // ready, me, done, busy, err, pen_db
  } vec_t;
  vec_t tbl[16];

  initial begin
    bit rRst, rValid, rPen, rLim, rFlt, rClr;
    int faultLeft;

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

    tbl[0]  = '{6'b000110, 6'b100000};
    tbl[1]  = '{6'b100110, 6'b100000};
    tbl[2]  = '{6'b110110, 6'b001100};
    tbl[3]  = '{6'b100110, 6'b100000};
    tbl[4]  = '{6'b110110, 6'b001100};
    tbl[5]  = '{6'b110110, 6'b100000};
    tbl[6]  = '{6'b100110, 6'b100000};
    tbl[7]  = '{6'b100100, 6'b100000};
    tbl[8]  = '{6'b100100, 6'b100000};
    tbl[9]  = '{6'b100100, 6'b000010};
    tbl[10] = '{6'b100101, 6'b000010};
    tbl[11] = '{6'b100110, 6'b000010};
    tbl[12] = '{6'b100111, 6'b000010};
    tbl[13] = '{6'b100111, 6'b100000};
    tbl[14] = '{6'b110110, 6'b001100};
    tbl[15] = '{6'b100110, 6'b100000};

    for (int i = 0; i < 16; i++) begin
      applyStimulus(tbl[i].stim[5], tbl[i].stim[4], tbl[i].stim[3],
                    tbl[i].stim[2], tbl[i].stim[1], tbl[i].stim[0]);
      tick();
      checkVec($sformatf("vec%0d", i),
               {cmdIf.cmd_ready, motor_enable, cmdIf.done, busy, error, pen_db}, tbl[i].expv);
      if (i == 0) begin
        checkWord("reset.duty", duty, 16'h0);
        checkBit("reset.set_pen", set_pen, 1'b0);
        checkBit("reset.timeout_err", timeout_err, 1'b0);
      end
    end

    // Normal move: pen up -> down, switch reaches "down" 20 cycles after the handshake.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    checkBit("move.me_start", motor_enable, 1'b1);
    checkWord("move.duty", duty, DUTY);
    checkBit("move.set_pen", set_pen, 1'b1);
    checkBit("move.busy", busy, 1'b1);
    cmdIf.cmd_valid = 1'b0;
    repeat (19) begin
      tick();
      checkBit("move.me_hold", motor_enable, 1'b1);
    end
    limit_switch = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      checkBit("move.me_arrive", motor_enable, 1'b1);
      checkBit("move.pen_db", pen_db, i == 6);
    end
    for (int i = 0; i < SET; i++) begin
      tick();
      checkBit("move.settle_me", motor_enable, 1'b0);
      checkWord("move.settle_duty", duty, 16'h0);
      checkBit("move.settle_done", cmdIf.done, 1'b0);
      checkBit("move.settle_busy", busy, 1'b1);
    end
    tick();
    checkBit("move.done", cmdIf.done, 1'b1);
    tick();
    checkBit("move.done_clear", cmdIf.done, 1'b0);
    checkBit("move.ready", cmdIf.cmd_ready, 1'b1);

    // Already positioned: done the cycle after the handshake, motor never on.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    checkBit("pos.done", cmdIf.done, 1'b1);
    checkBit("pos.me", motor_enable, 1'b0);
    cmdIf.cmd_valid = 1'b0;
    tick();
    checkBit("pos.done_clear", cmdIf.done, 1'b0);
    checkBit("pos.me2", motor_enable, 1'b0);
    checkBit("pos.ready", cmdIf.cmd_ready, 1'b1);

    // Bounce: return to up, chatter in 2-cycle runs, then settle at down.
    limit_switch = 1'b1;
    repeat (10) tick();
    checkBit("bounce.up", pen_db, 1'b0);
    for (int i = 0; i < 20; i++) begin
      limit_switch = ((i / 2) % 2 == 0) ? 1'b0 : 1'b1;
      tick();
      checkBit("bounce.hold", pen_db, 1'b0);
    end
    limit_switch = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      checkBit("bounce.settle", pen_db, i == 6);
    end

    // Request up while the switch stays at down: no arrival.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    checkBit("to.me_start", motor_enable, 1'b1);
    cmdIf.cmd_valid = 1'b0;
`ifdef PEN_TIMEOUT_EN
    for (int i = 1; i < TO; i++) begin
      tick();
      checkBit("to.drive", motor_enable, 1'b1);
    end
    tick();
    checkBit("to.error", error, 1'b1);
    checkBit("to.timeout_err", timeout_err, 1'b1);
    checkBit("to.me_off", motor_enable, 1'b0);
    checkBit("to.ready", cmdIf.cmd_ready, 1'b0);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    checkBit("to.clr_ready", cmdIf.cmd_ready, 1'b1);
    checkBit("to.clr_error", error, 1'b0);
    checkBit("to.clr_timeout", timeout_err, 1'b0);
`else
    for (int i = 1; i <= TO + 20; i++) begin
      tick();
      checkBit("nto.drive", motor_enable, 1'b1);
    end
    checkBit("nto.error", error, 1'b0);
    checkBit("nto.timeout_err", timeout_err, 1'b0);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
`endif

    // Reset mid-DRIVE, then the debounce re-acquires "down" from the reset value.
    repeat (8) tick();
    checkBit("rst.pre_pd", pen_db, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    checkBit("rst.drive", motor_enable, 1'b1);
    cmdIf.cmd_valid = 1'b0;
    repeat (5) tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    checkVec("rst.outputs", {cmdIf.cmd_ready, motor_enable, cmdIf.done, busy, error, pen_db},
             6'b100000);
    checkWord("rst.duty", duty, 16'h0);
    checkBit("rst.set_pen", set_pen, 1'b0);
    checkBit("rst.timeout_err", timeout_err, 1'b0);
    for (int i = 1; i <= 6; i++) begin
      tick();
      checkBit("rst.ready", cmdIf.cmd_ready, 1'b1);
      checkBit("rst.repd", pen_db, i == 6);
    end

    // Fault priority: synchronized fault lands on the same cycle as arrival.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    cmdIf.cmd_valid = 1'b0;
    repeat (2) tick();
    limit_switch = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (i == 4) fault_n = 1'b0;
    end
    checkBit("fp.arrived", pen_db, 1'b0);
    checkBit("fp.me", motor_enable, 1'b1);
    tick();
    checkBit("fp.error", error, 1'b1);
    checkBit("fp.me_off", motor_enable, 1'b0);
    checkBit("fp.no_done", cmdIf.done, 1'b0);
    checkBit("fp.busy", busy, 1'b0);
    clear_err = 1'b1;
    repeat (6) begin
      tick();
      checkBit("fp.held", error, 1'b1);
      checkBit("fp.held_done", cmdIf.done, 1'b0);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    repeat (3) tick();
    checkBit("fp.no_clr", error, 1'b1);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    checkBit("fp.clr_ready", cmdIf.cmd_ready, 1'b1);
    checkBit("fp.clr_error", error, 1'b0);

    // Randomized run against the model.
    rLim = 1'b1;
    faultLeft = 0;
    for (int i = 0; i < 2000; i++) begin
      rRst   = (i == 0) ? 1'b0 : ($urandom_range(0, 799) != 0);
      rValid = ($urandom_range(0, 2) == 0);
      rPen   = $urandom_range(0, 1) != 0;
      if ($urandom_range(0, 23) == 0) rLim = !rLim;
      if (faultLeft > 0) faultLeft--;
      else if ($urandom_range(0, 149) == 0) faultLeft = $urandom_range(3, 12);
      rFlt = (faultLeft == 0);
      rClr = ($urandom_range(0, 5) == 0);
      applyStimulus(rRst, rValid, rPen, rLim, rFlt, rClr);
      @(posedge clk_50);
      modelEdge(rRst, rValid, rPen, rLim, rFlt, rClr);
      #1;
      checkBit("rnd.ready", cmdIf.cmd_ready, mMode == M_IDLE);
      checkBit("rnd.me", motor_enable, mMode == M_MOVE);
      checkWord("rnd.duty", duty, (mMode == M_MOVE) ? DUTY : 16'h0);
      checkBit("rnd.done", cmdIf.done, mMode == M_FIN);
      checkBit("rnd.busy", busy, mMode == M_MOVE || mMode == M_WAIT || mMode == M_FIN);
      checkBit("rnd.error", error, mMode == M_ERR);
      checkBit("rnd.timeout_err", timeout_err, mTimeoutErr);
      checkBit("rnd.pen_db", pen_db, mPenDb);
      checkBit("rnd.set_pen", set_pen, mSetPen);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pen_lift_ctrl.md
PEN_LIFT_CTRL -- requirements
Module: pen_lift_ctrl

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 50000, meaning the number of cycles the limit switch must be stable before it is accepted (1 ms at 50 MHz).
REQ-002 The block SHALL have parameter SETTLE_CYCLES, default 500000, meaning the motor-off dwell after the target position is reached (10 ms).
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 25000000, meaning the maximum DRIVE duration (0.5 s).
REQ-004 The block SHALL have parameter DUTY_MOVE, default 16'd128, meaning the duty word presented while driving.
REQ-005 The block SHALL have input clk_50, width 1: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have input reset_n, width 1: synchronous, active-low reset.
REQ-007 Inputs cmd_valid (1, request present) and cmd_pen (1, requested pen position: 0 = up, 1 = down) SHALL be provided.
REQ-008 Input cmd_ready SHALL NOT exist; cmd_ready SHALL be an output (1) that is high only in IDLE.
REQ-009 Inputs limit_switch (1, raw: 0 = down, 1 = up), fault_n (1, raw, active-low driver fault) and clear_err (1, one-cycle error clear) SHALL be provided.
REQ-010 Outputs motor_enable (1), set_pen (1), duty (16), done (1, one-cycle pulse), error (1), timeout_err (1), pen_db (1, debounced position: 0 = up, 1 = down) and busy (1) SHALL be provided.

Function
REQ-011 limit_switch and fault_n SHALL each pass through a 2-flop synchronizer before use.
REQ-012 The synchronized limit_switch SHALL update pen_db = !sync only after it differs from the current accepted value for DEBOUNCE_CYCLES consecutive cycles; any bounce SHALL restart the count.
REQ-013 The FSM SHALL have the states IDLE, DRIVE, SETTLE, DONE and FAULT.
REQ-014 In IDLE, a handshake (cmd_valid and cmd_ready) SHALL latch cmd_pen into set_pen and move to DONE if pen_db == cmd_pen, otherwise to DRIVE.
REQ-015 In DRIVE, motor_enable SHALL be 1 and duty SHALL be DUTY_MOVE; pen_db == set_pen SHALL move the FSM to SETTLE on the next cycle.
REQ-016 In SETTLE, motor_enable SHALL be 0 for exactly SETTLE_CYCLES cycles, followed by DONE.
REQ-017 DONE SHALL last one cycle, with done = 1, and SHALL then return to IDLE; total handshake-to-done latency for an already-positioned pen SHALL be 1 cycle.
REQ-018 The DRIVE cycle counter SHALL saturate; reaching TIMEOUT_CYCLES without arrival SHALL move the FSM to FAULT with timeout_err = 1.
REQ-019 A synchronized fault_n = 0 in DRIVE, SETTLE or DONE SHALL move the FSM to FAULT next cycle with priority over arrival and timeout; done SHALL NOT pulse that cycle.
REQ-020 A fault_n = 0 seen in IDLE SHALL move the FSM to FAULT.
REQ-021 In FAULT, motor_enable SHALL be 0, error SHALL be 1, cmd_ready SHALL be 0, and requests SHALL be ignored.
REQ-022 clear_err with synchronized fault_n = 1 SHALL return FAULT to IDLE and clear error and timeout_err; clear_err while the fault persists SHALL have no effect.
REQ-023 busy SHALL be 1 in DRIVE, SETTLE and DONE.
REQ-024 duty SHALL be 0 in every state except DRIVE.
REQ-025 set_pen SHALL hold its value outside the handshake.

Reset
REQ-026 reset_n = 0 at any clock edge, including mid-DRIVE, SHALL force IDLE and clear all counters.
REQ-027 Reset SHALL set motor_enable = 0, duty = 0, set_pen = 0, done = 0, error = 0, timeout_err = 0 and busy = 0.
REQ-028 Reset SHALL set pen_db = 0 and the synchronizer flops to limit = 1 and fault_n = 1.
REQ-029 After reset, cmd_ready SHALL be 1 from the first cycle following reset release.

Configuration
REQ-030 Macro PEN_TIMEOUT_EN defined: the DRIVE timeout counter and timeout_err SHALL operate per REQ-018.
REQ-031 PEN_TIMEOUT_EN undefined: the timeout counter SHALL be omitted, DRIVE SHALL wait indefinitely for arrival or fault, and timeout_err SHALL be tied to 0.

Verification (bench parameters: DEBOUNCE_CYCLES=4, SETTLE_CYCLES=8, TIMEOUT_CYCLES=100, DUTY_MOVE=16'h80)
REQ-032 Scenario (normal move): pen up, cmd_pen=1 handshake, limit_switch to 0 after 20 cycles -> motor_enable=1, duty=16'h80 until pen_db=1, then 8 off cycles, then a single done pulse.
REQ-033 Scenario (already positioned): pen_db=1, cmd_pen=1 -> done high exactly 1 cycle after the handshake, and motor_enable never asserts.
REQ-034 Scenario (bounce): limit_switch toggles every 2 cycles for 20 cycles, then settles at 0 -> pen_db changes only 4 cycles after the last edge plus sync delay.
REQ-035 Scenario (timeout, PEN_TIMEOUT_EN): no arrival -> FAULT after 100 DRIVE cycles with error=1, timeout_err=1, motor_enable=0; clear_err -> IDLE with cmd_ready=1.
REQ-036 Scenario (fault priority): fault_n=0 on the same cycle pen_db reaches the target -> FAULT with no done pulse; clear_err while fault_n=0 -> FAULT is held.
REQ-037 Scenario (reset mid-DRIVE): reset_n=0 for 1 cycle during DRIVE -> IDLE next cycle with all outputs at their reset values.
